powerup_ctrl: RTL and testbench
===============================

# powerup_ctrl

Consumes pickup-collection events from the pickup generator and runs the power-up game loop. It holds a per-tank power-up timer that counts in frames and drives each tank's boost flag. After a cooldown it issues the one-cycle regeneration request (`Gen`) that makes the pickup generator place a new pickup. It sits between the pickup generator and the tank motion/firing logic, and is clocked by the system clock with a frame-rate enable.

## Interface
Parameters:
- `DURATION`, 8'd180 — boost length in frames granted per pickup.
- `COOLDOWN`, 8'd120 — frames between a collection and the next spawn request.

Ports:
- `Clk`  in  1 — system clock.
- `Reset_h`  in  1 — reset; one clock; reset is synchronous and active-high.
- `frame_tick`  in  1 — one-cycle pulse per video frame (vsync-derived).
- `tank1pick`  in  1 — level from pickup generator; tank 1 overlaps the pickup.
- `tank2pick`  in  1 — level from pickup generator; tank 2 overlaps the pickup.
- `Gen`  out  1 — one-cycle spawn request to the pickup generator.
- `pickup_visible`  out  1 — high while a pickup is on the field (state ACTIVE).
- `tank1_boost`  out  1 — tank 1 power-up active (`t1_timer` != 0).
- `tank2_boost`  out  1 — tank 2 power-up active (`t2_timer` != 0).
- `t1_timer`  out  8 — tank 1 remaining boost frames.
- `t2_timer`  out  8 — tank 2 remaining boost frames.
- `cd_timer`  out  8 — remaining cooldown frames, for HUD/debug.

## Operation
- Pick inputs are registered and rising-edge detected.
  - A pick event is `tankNpick & ~tankNpick_q`.
  - Events are honoured only in ACTIVE; outside ACTIVE they are ignored.
- FSM states:
  - SPAWN → ACTIVE: unconditional, one cycle; `Gen`=1 in SPAWN only.
  - ACTIVE → COOLDOWN: on any pick event; `cd_timer` is loaded with `COOLDOWN`.
  - ACTIVE, no event: stay in ACTIVE.
  - COOLDOWN → SPAWN: when `cd_timer`==0; otherwise `cd_timer` decrements on each `frame_tick`.
- Simultaneous pick events from both tanks: tank 1 wins, and only tank 1 is awarded.
- Award rule: the winning tank's timer is loaded with `DURATION`. The stacking variant is described under Configuration.
- Per-tank timer, per cycle:
  - A load in the same cycle as `frame_tick` takes priority; no decrement that cycle.
  - Otherwise the timer decrements on `frame_tick` while nonzero.
  - The timer saturates at 0 and never wraps.
- `DURATION`=0 is legal: the award has no visible effect.
- `COOLDOWN`=0 is legal: COOLDOWN lasts exactly one cycle.

## Timing
- Reset values:
  - State = SPAWN.
  - `Gen`=0, `pickup_visible`=0, `tank1_boost`=0, `tank2_boost`=0.
  - `t1_timer`=0, `t2_timer`=0, `cd_timer`=0.
  - Edge-detect registers = 0.
- All outputs are registered.
- First cycle after `Reset_h` deasserts: `Gen`=1. Next cycle: `Gen`=0, `pickup_visible`=1.
- Pick latency:
  - `tankNpick` rises at edge k.
  - The event is detected combinationally from the input and the registered copy.
  - At edge k+1: state=COOLDOWN, `pickup_visible`=0, timer loaded, boost=1.
- Cooldown length is `COOLDOWN` frame_ticks plus 1 cycle; `Gen` pulses the cycle after `cd_timer` is observed at 0.
- A pick input held high across SPAWN→ACTIVE does not retrigger. Only a new rising edge counts, because the edge-detect register keeps updating in every state.
- Reset asserted mid-cooldown or mid-boost: all timers clear on the next edge and the FSM restarts at SPAWN.

## Configuration
- `POWERUP_STACK_EN` defined: an award adds `DURATION` to the current timer, saturating at 8'hFF.
- `POWERUP_STACK_EN` undefined: an award reloads the timer to `DURATION`, discarding any remainder.
- Nothing else changes with the macro.

## Test plan
- Reset release, no picks → `Gen` high for exactly 1 cycle, then `pickup_visible`=1 and held; all timers 0.
- Single `tank1pick` rise in ACTIVE, `DURATION`=180, `COOLDOWN`=120, `frame_tick` every 4 cycles:
  - next cycle: `t1_timer`=180, `tank1_boost`=1, `cd_timer`=120;
  - after 120 ticks plus 1 cycle: `Gen` pulse;
  - `tank1_boost` drops after 180 ticks.
- `tank1pick` and `tank2pick` rise in the same cycle → only `t1_timer`=180; `t2_timer` stays 0.
- Pick while `t1_timer`=50 (second pickup):
  - without macro: `t1_timer`=180;
  - with `POWERUP_STACK_EN`: 230;
  - with `POWERUP_STACK_EN` at `t1_timer`=200: 255.
- `tank2pick` held high from COOLDOWN through the spawn → no award in ACTIVE until it falls and rises again.
- `Reset_h` asserted mid-cooldown with `t2_timer`=90 → next cycle all timers 0; then `Gen` pulses the cycle after `Reset_h` falls.

Source files
------------

// File: rtl/powerup_ctrl_if.sv
// powerup_ctrl_if -- signal bundle between the power-up controller and its
// neighbours (pickup generator, tank motion/firing logic, HUD).
//   frame_tick     : one-cycle pulse per video frame
//   tank1pick/2    : tank overlaps the current pickup (level)
//   Gen            : one-cycle spawn request to the pickup generator
//   pickup_visible : a pickup is on the field
//   tankN_boost    : tank N power-up active
//   tN_timer       : tank N remaining boost frames
//   cd_timer       : remaining cooldown frames
// The slave modport is the controller's view; master is the environment's.
interface powerup_ctrl_if;
  logic       frame_tick;
  logic       tank1pick;
  logic       tank2pick;
  logic       Gen;
  logic       pickup_visible;
  logic       tank1_boost;
  logic       tank2_boost;
  logic [7:0] t1_timer;
  logic [7:0] t2_timer;
  logic [7:0] cd_timer;

  modport slave (
    input  frame_tick, tank1pick, tank2pick,
    output Gen, pickup_visible, tank1_boost, tank2_boost,
           t1_timer, t2_timer, cd_timer
  );

  modport master (
    output frame_tick, tank1pick, tank2pick,
    input  Gen, pickup_visible, tank1_boost, tank2_boost,
           t1_timer, t2_timer, cd_timer
  );
endinterface

// File: rtl/powerup_ctrl.sv
// powerup_ctrl -- power-up game loop.
// Edge-detects pickup collections, grants per-tank boost timers counted in
// frames, waits a cooldown, then requests a new pickup with a one-cycle Gen.
// Ports:
//   Clk     : system clock
//   Reset_h : synchronous active-high reset
//   bus     : powerup_ctrl_if.slave (frame_tick, pick inputs; Gen,
//             pickup_visible, boost flags, t1/t2/cd timers)
// Parameters: DURATION (boost frames per award), COOLDOWN (frames before respawn).
// Build option: POWERUP_STACK_EN -- an award adds DURATION to the remaining
// time (saturating at 8'hFF) instead of reloading it.
module powerup_ctrl #(
  parameter logic [7:0] DURATION = 8'd180,
  parameter logic [7:0] COOLDOWN = 8'd120
) (
  input  logic           Clk,
  input  logic           Reset_h,
  powerup_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_SPAWN    = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       pick1_q, pick2_q;
  logic [7:0] t1_q, t1_d;
  logic [7:0] t2_q, t2_d;
  logic [7:0] cd_q, cd_d;
  logic       gen_q, gen_d;
  logic       vis_q, vis_d;
  logic       b1_q, b1_d;
  logic       b2_q, b2_d;

  logic ev1, ev2, award1, award2;

  // Rising edges only count while a pickup is on the field; tank 1 wins ties.
  assign ev1    = bus.tank1pick & ~pick1_q & (state_q == ST_ACTIVE);
  assign ev2    = bus.tank2pick & ~pick2_q & (state_q == ST_ACTIVE);
  assign award1 = ev1;
  assign award2 = ev2 & ~ev1;

  function automatic logic [7:0] next_timer(input logic [7:0] cur,
                                            input logic       award,
                                            input logic       tick);
    logic [7:0] load;
`ifdef POWERUP_STACK_EN
    logic [8:0] sum;
    sum  = {1'b0, cur} + {1'b0, DURATION};
    load = sum[8] ? 8'hFF : sum[7:0];
`else
    load = DURATION;
`endif
    if (award)
      next_timer = load;
    else if (tick && (cur != '0))
      next_timer = cur - 8'd1;
    else
      next_timer = cur;
  endfunction

  // State register (plus registered datapath and outputs)
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state_q <= ST_SPAWN;
      pick1_q <= 1'b0;
      pick2_q <= 1'b0;
      t1_q    <= '0;
      t2_q    <= '0;
      cd_q    <= '0;
      gen_q   <= 1'b0;
      vis_q   <= 1'b0;
      b1_q    <= 1'b0;
      b2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pick1_q <= bus.tank1pick;
      pick2_q <= bus.tank2pick;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      cd_q    <= cd_d;
      gen_q   <= gen_d;
      vis_q   <= vis_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
    end
  end

  // Next-state logic.
  // SPAWN leaves only once Gen has been issued: out of reset Gen is still 0,
  // so the first post-reset cycle stays in SPAWN to raise it; entering SPAWN
  // from COOLDOWN raises Gen on the same edge, so that visit lasts one cycle.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    unique case (state_q)
      ST_SPAWN: begin
        if (gen_q) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (ev1 || ev2) begin
          state_d = ST_COOLDOWN;
          cd_d    = COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (cd_q == '0)
          state_d = ST_SPAWN;
        else if (bus.frame_tick)
          cd_d = cd_q - 8'd1;
      end
      default: state_d = ST_SPAWN;
    endcase
  end

  // Output logic: registered outputs decode the upcoming state and timers.
  always_comb begin
    t1_d  = next_timer(t1_q, award1, bus.frame_tick);
    t2_d  = next_timer(t2_q, award2, bus.frame_tick);
    gen_d = (state_d == ST_SPAWN);
    vis_d = (state_d == ST_ACTIVE);
    b1_d  = (t1_d != '0);
    b2_d  = (t2_d != '0);
  end

  assign bus.Gen            = gen_q;
  assign bus.pickup_visible = vis_q;
  assign bus.tank1_boost    = b1_q;
  assign bus.tank2_boost    = b2_q;
  assign bus.t1_timer       = t1_q;
  assign bus.t2_timer       = t2_q;
  assign bus.cd_timer       = cd_q;

endmodule

// File: tb/tb_powerup_ctrl.sv
// tb_powerup_ctrl -- directed self-checking bench for powerup_ctrl
// (DURATION=180, COOLDOWN=120). A short vector table covers reset release,
// spawn and a simultaneous pick; hand sequences cover the long cooldown,
// re-award with tick priority, held-pick no-retrigger and mid-cooldown reset.
module tb_powerup_ctrl;

  logic Clk;
  logic Reset_h;
  powerup_ctrl_if bus ();

  powerup_ctrl #(.DURATION(8'd180), .COOLDOWN(8'd120)) dut (
    .Clk     (Clk),
    .Reset_h (Reset_h),
    .bus     (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit rst, tick, p1, p2;
    bit gen, vis, b1, b2;
    int t1, t2, cd;
  } vec_t;

  vec_t vecs[9];
  int checks   = 0;
  int failures = 0;

`ifdef POWERUP_STACK_EN
  localparam int REAWARD = 230;
`else
  localparam int REAWARD = 180;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit gen, input bit vis,
                         input bit b1, input bit b2,
                         input int t1, input int t2, input int cd);
    chk({tag, ".Gen"},  int'(bus.Gen), int'(gen));
    chk({tag, ".vis"},  int'(bus.pickup_visible), int'(vis));
    chk({tag, ".b1"},   int'(bus.tank1_boost), int'(b1));
    chk({tag, ".b2"},   int'(bus.tank2_boost), int'(b2));
    chk({tag, ".t1"},   int'(bus.t1_timer), t1);
    chk({tag, ".t2"},   int'(bus.t2_timer), t2);
    chk({tag, ".cd"},   int'(bus.cd_timer), cd);
  endtask

  // Drive inputs away from the edge, clock once, sample 1 time unit later.
  task automatic step(input bit rst, input bit tick, input bit p1, input bit p2);
    Reset_h        = rst;
    bus.frame_tick = tick;
    bus.tank1pick  = p1;
    bus.tank2pick  = p2;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int t1m;

    //             rst tk p1 p2  gen vis b1 b2  t1   t2  cd
    vecs[0] = '{1, 0, 0, 0,  0, 0, 0, 0,   0,  0,   0};
    vecs[1] = '{1, 0, 0, 0,  0, 0, 0, 0,   0,  0,   0};
    vecs[2] = '{0, 0, 0, 0,  1, 0, 0, 0,   0,  0,   0};
    vecs[3] = '{0, 0, 0, 0,  0, 1, 0, 0,   0,  0,   0};
    vecs[4] = '{0, 1, 0, 0,  0, 1, 0, 0,   0,  0,   0};
    vecs[5] = '{0, 0, 1, 1,  0, 0, 1, 0, 180,  0, 120};
    vecs[6] = '{0, 1, 1, 1,  0, 0, 1, 0, 179,  0, 119};
    vecs[7] = '{0, 0, 0, 0,  0, 0, 1, 0, 179,  0, 119};
    vecs[8] = '{0, 1, 0, 0,  0, 0, 1, 0, 178,  0, 118};

    Reset_h        = 1'b1;
    bus.frame_tick = 1'b0;
    bus.tank1pick  = 1'b0;
    bus.tank2pick  = 1'b0;

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].rst, vecs[i].tick, vecs[i].p1, vecs[i].p2);
      chk_all($sformatf("vec%0d", i), vecs[i].gen, vecs[i].vis, vecs[i].b1,
              vecs[i].b2, vecs[i].t1, vecs[i].t2, vecs[i].cd);
    end

    // Cooldown with frame_tick every 4 cycles: 118 more ticks empty it.
    for (int i = 0; i < 118; i++) begin
      for (int j = 0; j < 3; j++) step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("cool.noGen", int'(bus.Gen), 0);
    end
    chk_all("cool.end", 0, 0, 1, 0, 60, 0, 0);
    step(0, 0, 0, 0);
    chk("respawn.Gen", int'(bus.Gen), 1);
    chk("respawn.vis", int'(bus.pickup_visible), 0);
    step(0, 0, 0, 0);
    chk("active.Gen", int'(bus.Gen), 0);
    chk("active.vis", int'(bus.pickup_visible), 1);

    // Bring t1 to 50, then re-award in a tick cycle (load beats decrement).
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    chk("t1.at50", int'(bus.t1_timer), 50);
    step(0, 1, 1, 0);
    chk_all("reaward", 0, 0, 1, 0, REAWARD, 0, 120);
    t1m = REAWARD;

    // tank2 rises in COOLDOWN and stays high through the respawn.
    step(0, 0, 0, 1);
    chk_all("p2.cool", 0, 0, 1, 0, t1m, 0, 120);
    for (int i = 0; i < 120; i++) begin
      step(0, 1, 0, 1);
      chk("p2.noGen", int'(bus.Gen), 0);
    end
    t1m -= 120;
    chk("p2.cd0", int'(bus.cd_timer), 0);
    step(0, 0, 0, 1);
    chk("p2.Gen", int'(bus.Gen), 1);
    step(0, 0, 0, 1);
    chk_all("p2.active", 0, 1, 1, 0, t1m, 0, 0);
    step(0, 0, 0, 1);
    chk_all("p2.held", 0, 1, 1, 0, t1m, 0, 0);
    step(0, 0, 0, 0);
    chk("p2.low.vis", int'(bus.pickup_visible), 1);
    step(0, 0, 0, 1);
    chk_all("p2.award", 0, 0, 1, 1, t1m, 180, 120);

    // Burn 90 ticks (t2 -> 90, t1 saturates), then reset mid-cooldown.
    for (int i = 0; i < 90; i++) step(0, 1, 0, 1);
    t1m = (t1m > 90) ? t1m - 90 : 0;
    chk_all("mid.cool", 0, 0, (t1m != 0), 1, t1m, 90, 30);
    step(1, 0, 0, 0);
    chk_all("rst.mid", 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk_all("rst.Gen", 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk_all("rst.active", 0, 1, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
